// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// RV32M funct3 codes and a helper that classifies an op as a divide.
package md_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [2:0] MUL    = 3'd0;
   localparam logic [2:0] MULH   = 3'd1;
   localparam logic [2:0] MULHSU = 3'd2;
   localparam logic [2:0] MULHU  = 3'd3;
   localparam logic [2:0] DIV    = 3'd4;
   localparam logic [2:0] DIVU   = 3'd5;
   localparam logic [2:0] REM    = 3'd6;
   localparam logic [2:0] REMU   = 3'd7;

   // funct3[2] separates the divide/remainder group from the multiplies
   function automatic logic is_div(input logic [2:0] funct3);
      return funct3[2];
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EXE-stage request/response bundle between the pipeline (master) and the
// multiply/divide sequencer (slave).
interface muldiv_sequencer_if;
   logic       md_valid_EXE;
   logic [2:0] md_op_EXE;
   logic [4:0] rd_EXE;
   logic       div_zero_EXE;
   logic       kill_EXE;
   logic       md_start;
   logic       md_step;
   logic [2:0] md_op;
   logic [4:0] md_rd;
   logic       md_div0;
   logic       md_stall;
   logic       md_busy;
   logic       md_done;

   modport master (
      output md_valid_EXE, md_op_EXE, rd_EXE, div_zero_EXE, kill_EXE,
      input  md_start, md_step, md_op, md_rd, md_div0, md_stall, md_busy, md_done
   );

   modport slave (
      input  md_valid_EXE, md_op_EXE, rd_EXE, div_zero_EXE, kill_EXE,
      output md_start, md_step, md_op, md_rd, md_div0, md_stall, md_busy, md_done
   );
endinterface

// File: rtl/md_lat_counter.sv
// Iteration down-counter: loads LAT-1 at start, decrements once per RUN
// cycle, flags zero on the last iteration, and clears on abort.
module md_lat_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // count register: clear has priority, then load, then saturating decrement
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller for the EXE stage. Starts the
// datapath, counts iterations, stalls the pipeline and pulses done when the
// result may advance to EXE/MEM.
// Optional feature: define MULDIV_DIV0_FAST_EN to retire divide-by-zero in
// two cycles with md_div0 set instead of running the full divide.
module muldiv_sequencer
   import md_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 32
) (
   input logic               clk,
   input logic               rst,
   muldiv_sequencer_if.slave bus
);

   localparam int CNT_W = $clog2(DIV_LAT + 1);

   state_e     state_q, state_d;
   logic       start_c, step_c, stall_c, done_c;
   logic       load_c, dec_c, clr_c, latch_c, div0_set_c;
   logic       cnt_zero;
   logic       fast_div0;
   logic [CNT_W-1:0] load_val;
   logic [2:0] op_q;
   logic [4:0] rd_q;

   assign load_val = is_div(bus.md_op_EXE) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

`ifdef MULDIV_DIV0_FAST_EN
   assign fast_div0 = is_div(bus.md_op_EXE) & bus.div_zero_EXE;
`else
   assign fast_div0 = 1'b0;
`endif

   md_lat_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_c),
      .load     (load_c),
      .dec      (dec_c),
      .load_val (load_val),
      .zero     (cnt_zero)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and strobes; start/stall in IDLE follow the EXE inputs directly
   always_comb begin
      state_d    = state_q;
      start_c    = 1'b0;
      step_c     = 1'b0;
      stall_c    = 1'b0;
      done_c     = 1'b0;
      load_c     = 1'b0;
      dec_c      = 1'b0;
      clr_c      = 1'b0;
      latch_c    = 1'b0;
      div0_set_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.md_valid_EXE && !bus.kill_EXE) begin
               stall_c = 1'b1;
               latch_c = 1'b1;
               if (fast_div0) begin
                  div0_set_c = 1'b1;
                  state_d    = DONE;
               end else begin
                  start_c = 1'b1;
                  load_c  = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (bus.kill_EXE) begin
               clr_c   = 1'b1;
               state_d = IDLE;
            end else begin
               step_c  = 1'b1;
               stall_c = 1'b1;
               dec_c   = 1'b1;
               if (cnt_zero) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // stall is released here so the result leaves EXE on this edge
            done_c  = !bus.kill_EXE;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // result tag: op/rd captured on acceptance and held until the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= 3'd0;
         rd_q <= 5'd0;
      end else if (latch_c) begin
         op_q <= bus.md_op_EXE;
         rd_q <= bus.rd_EXE;
      end
   end

`ifdef MULDIV_DIV0_FAST_EN
   logic div0_q;

   // divide-by-zero flag lives only for the DONE cycle of a fast retire
   always_ff @(posedge clk) begin
      if (rst) begin
         div0_q <= 1'b0;
      end else if (div0_set_c) begin
         div0_q <= 1'b1;
      end else if (state_q == DONE) begin
         div0_q <= 1'b0;
      end
   end

   assign bus.md_div0 = div0_q;
`else
   logic unused_div0_ctl;
   assign unused_div0_ctl = bus.div_zero_EXE ^ div0_set_c;
   assign bus.md_div0     = 1'b0;
`endif

   assign bus.md_start = start_c;
   assign bus.md_step  = step_c;
   assign bus.md_stall = stall_c;
   assign bus.md_done  = done_c;
   assign bus.md_busy  = (state_q != IDLE);
   assign bus.md_op    = op_q;
   assign bus.md_rd    = rd_q;

endmodule
